// File: rtl/pkg_rolhas.sv
// Shared definitions for the cork-count BCD/binary conversion path.
package pkg_rolhas;

   localparam int unsigned W_BCD    = 4;
   localparam int unsigned W_ROLHAS = 7;

   localparam int LIMITE_PADRAO = 99;

   localparam logic [W_ROLHAS-1:0] DEZ = 7'd10;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ACUMULA = 2'd1,
      PRONTO  = 2'd2
   } estado_t;

endpackage

// File: rtl/modulo_valida_bcd.sv
// Combinational BCD digit check: flags whether a 4-bit digit is in 0..9.
module modulo_valida_bcd
   import pkg_rolhas::*;
(
   input  logic [W_BCD-1:0] digito,
   output logic             valido
);

   // A digit is legal BCD only up to nine
   assign valido = (digito <= 4'd9);

endmodule

// File: rtl/modulo_decodificador_rolhas.sv
// Sequential BCD-to-binary cork count converter: the tens digit is folded in
// by repeated add-10 steps, with valid/ready handshakes on input and output.
module modulo_decodificador_rolhas
   import pkg_rolhas::*;
#(
   parameter int LIMITE = LIMITE_PADRAO
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [W_BCD-1:0]    reg_rd,
   input  logic [W_BCD-1:0]    reg_ru,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [W_ROLHAS-1:0] reg_r,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                erro
);

   estado_t               estado;
   logic [W_ROLHAS-1:0]   acc;
   logic [W_BCD-1:0]      cnt;
   logic                  dezena_ok;
   logic                  unidade_ok;

   modulo_valida_bcd u_valida_dezena (
      .digito (reg_rd),
      .valido (dezena_ok)
   );

   modulo_valida_bcd u_valida_unidade (
      .digito (reg_ru),
      .valido (unidade_ok)
   );

   // Handshake flags come straight off the state register
   assign in_ready  = (estado == OCIOSO);
   assign out_valid = (estado == PRONTO);

   // Control FSM plus the acc/cnt accumulation datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         estado <= OCIOSO;
         acc    <= '0;
         cnt    <= '0;
         reg_r  <= '0;
         erro   <= 1'b0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (in_valid) begin
                  cnt <= reg_rd;
                  acc <= W_ROLHAS'(reg_ru);
                  if (!dezena_ok || !unidade_ok) begin
                     erro   <= 1'b1;
                     reg_r  <= '0;
                     estado <= PRONTO;
                  end else begin
                     erro   <= 1'b0;
                     estado <= ACUMULA;
                  end
               end
            end
            ACUMULA: begin
               if (cnt != '0) begin
                  acc <= acc + DEZ;
                  cnt <= cnt - 4'd1;
               end else if (int'(acc) <= LIMITE) begin
                  reg_r  <= acc;
                  estado <= PRONTO;
               end else begin
                  reg_r  <= '0;
                  erro   <= 1'b1;
                  estado <= PRONTO;
               end
            end
            PRONTO: begin
               if (out_ready) estado <= OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

endmodule
